// File: rtl/uart_tx_engine_pkg.sv
// Shared types and constants for the random-bit UART dump path
// (transmit engine and the generate/transmit controller).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

  // Clocks per bit, rounded to the nearest whole cycle.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte-write handshake between the dump controller (master) and the
// UART transmit engine (slave).
interface uart_tx_engine_if;
  logic [7:0] din;
  logic       wr_en;
  logic       tx_busy;
  logic       line_active;
  logic       tx_done;
  logic       overrun;

  modport master (
    output din, wr_en,
    input  tx_busy, line_active, tx_done, overrun
  );

  modport slave (
    input  din, wr_en,
    output tx_busy, line_active, tx_done, overrun
  );
endinterface

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-period timer: restartable counter that flags the last cycle of each
// bit period (bit_tick) and the cycle before it (pre_tick).
module uart_baud_gen #(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(BIT_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (restart || bit_tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign bit_tick = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter (8N1/8E1/8O1/8N2) with a one-byte holding
// register so consecutive frames leave the pin with no idle gap.
//
// state  | meaning
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (0)
// DATA   | data bits, LSB first, idx 0..7
// PARITY | optional parity bit
// STOP   | STOP_BITS stop bits (1); tx_done in the final clock
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_engine_if.slave   bus,
  output logic              tx
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);

  tx_state_t  state, state_n;
  logic [7:0] shift, shift_n;
  logic [7:0] hold;
  logic [2:0] idx, idx_n;
  logic       stop_cnt, stop_n;
  logic       par_bit, par_n;
  logic       hold_full;
  logic       load;
  logic       tx_q, tx_n;
  logic       done_q, done_n;
  logic       overrun_q;
  logic       active_q;
  logic       bit_tick, pre_tick;
  logic       stop_last;

  uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (load),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  assign stop_last = (STOP_BITS == 1) || stop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    stop_n  = stop_cnt;
    par_n   = par_bit;
    load    = 1'b0;
    done_n  = 1'b0;
    tx_n    = 1'b1;

    case (state)
      IDLE: begin
        if (hold_full)
          load = 1'b1;
      end
      START: begin
        if (bit_tick)
          state_n = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == 3'd7) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
            idx_n   = 3'd0;
            stop_n  = 1'b0;
          end else begin
            idx_n   = idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_n = STOP;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        // Registered tx_done must already be high in the last clock.
        if (stop_last && pre_tick)
          done_n = 1'b1;
        if (bit_tick) begin
          if (!stop_last)
            stop_n = 1'b1;
          else if (hold_full)
            load = 1'b1;
          else
            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      state_n = START;
      shift_n = hold;
      idx_n   = 3'd0;
      stop_n  = 1'b0;
      par_n   = (PARITY_ODD != 0) ? ~^hold : ^hold;
    end

    // tx is registered, so it follows the state being entered.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift     <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      shift     <= shift_n;
      idx       <= idx_n;
      stop_cnt  <= stop_n;
      par_bit   <= par_n;
      tx_q      <= tx_n;
      done_q    <= done_n;
      overrun_q <= bus.wr_en && hold_full;
      active_q  <= (state_n != IDLE);
      // Transfer only happens when full, accept only when empty.
      if (load) begin
        hold_full <= 1'b0;
      end else if (bus.wr_en && !hold_full) begin
        hold_full <= 1'b1;
        hold      <= bus.din;
      end
    end
  end

  assign tx              = tx_q;
  assign bus.tx_busy     = hold_full;
  assign bus.line_active = active_q;
  assign bus.tx_done     = done_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: three configurations, a bit-level
// receiver model per line and per-line queues of expected bytes.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic clk;
  logic reset_n;
  logic tx_a, tx_b, tx_c;

  uart_tx_engine_if if_a ();
  uart_tx_engine_if if_b ();
  uart_tx_engine_if if_c ();

  uart_tx_engine dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a),
    .tx      (tx_a)
  );

  uart_tx_engine #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (2)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b),
    .tx      (tx_b)
  );

  uart_tx_engine #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut_c (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_c),
    .tx      (tx_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Receiver configuration per line: bit cycles, bits per frame, framing.
  int   cfg_b[3]    = '{434, 10, 10};
  int   cfg_nb[3]   = '{10, 12, 10};
  bit   cfg_pen[3]  = '{1'b0, 1'b1, 1'b0};
  bit   cfg_podd[3] = '{1'b0, 1'b0, 1'b0};
  int   cfg_stop[3] = '{1, 2, 1};

  logic        rx_busy[3]   = '{1'b0, 1'b0, 1'b0};
  int          rx_cnt[3]    = '{0, 0, 0};
  logic [11:0] rx_bits[3];
  int          rx_frames[3] = '{0, 0, 0};
  int          ovr_a = 0;
  int          ovr_c = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int id);
    case (id)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0:       return if_a.tx_done;
      1:       return if_b.tx_done;
      default: return if_c.tx_done;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0:       return if_a.tx_busy;
      1:       return if_b.tx_busy;
      default: return if_c.tx_busy;
    endcase
  endfunction

  function automatic logic get_active(input int id);
    case (id)
      0:       return if_a.line_active;
      1:       return if_b.line_active;
      default: return if_c.line_active;
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push(input int id, input logic [7:0] b);
    case (id)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Expected line levels, one entry per bit period; unused tail stays 1.
  function automatic logic [11:0] build_frame(input logic [7:0] b, input bit pen,
                                              input bit podd, input int nstop);
    logic [11:0] f;
    int ones;
    int n;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = b[i];
      if (b[i]) ones++;
    end
    n = 9;
    if (pen) begin
      f[9] = podd ? (ones % 2 == 0) : (ones % 2 == 1);
      n = 10;
    end
    for (int s = 0; s < nstop; s++) f[n+s] = 1'b1;
    return f;
  endfunction

  task automatic rx_finish(input int id);
    logic [7:0] e;
    int n;
    n = qsize(id);
    chk($sformatf("rx%0d_pending", id), 32'(n > 0), 32'd1);
    if (n > 0) begin
      e = qpop(id);
      chk($sformatf("rx%0d_frame", id), 32'(rx_bits[id]),
          32'(build_frame(e, cfg_pen[id], cfg_podd[id], cfg_stop[id])));
    end
    rx_frames[id]++;
  endtask

  // Mid-bit sampling receiver; an abandoned frame is dropped on reset.
  task automatic rx_step(input int id, input logic line);
    int half;
    int j;
    half = cfg_b[id] / 2;
    if (reset_n !== 1'b1) begin
      rx_busy[id] = 1'b0;
    end else if (!rx_busy[id]) begin
      if (line === 1'b0) begin
        rx_busy[id] = 1'b1;
        rx_cnt[id]  = 0;
        rx_bits[id] = '1;
      end
    end else begin
      rx_cnt[id]++;
      if (rx_cnt[id] >= half && ((rx_cnt[id] - half) % cfg_b[id]) == 0) begin
        j = (rx_cnt[id] - half) / cfg_b[id];
        rx_bits[id][j] = line;
        if (j == cfg_nb[id] - 1) begin
          rx_busy[id] = 1'b0;
          rx_finish(id);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    rx_step(0, tx_a);
    rx_step(1, tx_b);
    rx_step(2, tx_c);
    if (if_a.overrun === 1'b1) ovr_a++;
    if (if_c.overrun === 1'b1) ovr_c++;
  end

  task automatic drive(input int id, input logic w, input logic [7:0] d);
    case (id)
      0: begin if_a.wr_en = w; if_a.din = d; end
      1: begin if_b.wr_en = w; if_b.din = d; end
      default: begin if_c.wr_en = w; if_c.din = d; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic write(input int id, input logic [7:0] b);
    drive(id, 1'b1, b);
    @(negedge clk);
    drive(id, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int id, input int budget);
    int n;
    n = 0;
    while (get_active(id) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle%0d_timeout", id), 32'(n < budget), 32'd1);
  endtask

  task automatic wait_not_busy(input int id, input int budget);
    int n;
    n = 0;
    while (get_busy(id) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("busy%0d_timeout", id), 32'(n < budget), 32'd1);
  endtask

  // Entered at the first cycle of the start bit; checks every clock.
  task automatic check_frame(input int id, input logic [7:0] b, input int bc,
                             input int nb, input bit pen, input bit podd,
                             input int nstop);
    logic [11:0] f;
    int match[12];
    int dcnt;
    int dat;
    f    = build_frame(b, pen, podd, nstop);
    dcnt = 0;
    dat  = -1;
    for (int p = 0; p < 12; p++) match[p] = 0;
    for (int k = 0; k < nb * bc; k++) begin
      if (get_tx(id) === f[k/bc]) match[k/bc]++;
      if (get_done(id) === 1'b1) begin
        dcnt++;
        dat = k;
      end
      if (k < nb * bc - 1) @(negedge clk);
    end
    for (int p = 0; p < nb; p++)
      chk($sformatf("frame%0d_bit%0d_cycles", id, p), match[p], bc);
    chk($sformatf("frame%0d_done_count", id), dcnt, 1);
    chk($sformatf("frame%0d_done_cycle", id), dat, nb * bc - 1);
  endtask

  initial begin
    int k;
    int nd;
    int d0;
    int d1;
    logic prev;
    logic [7:0] ch;

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", if_a.tx_busy, 0);
    chk("rst_active", if_a.line_active, 0);
    chk("rst_done", if_a.tx_done, 0);
    chk("rst_overrun", if_a.overrun, 0);
    chk("rst_tx_b", tx_b, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Single '1' at default rate, exact bit timing.
    write(0, 8'h31);
    push(0, 8'h31);
    chk("acc_busy_e", if_a.tx_busy, 1);
    chk("acc_tx_e", tx_a, 1);
    chk("acc_active_e", if_a.line_active, 0);
    @(negedge clk);
    chk("acc_busy_e1", if_a.tx_busy, 0);
    chk("acc_tx_e1", tx_a, 0);
    chk("acc_active_e1", if_a.line_active, 1);
    check_frame(0, 8'h31, 434, 10, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("post_active", if_a.line_active, 0);
    chk("post_tx", tx_a, 1);

    // Back-to-back '0' then '1'.
    repeat (3) @(negedge clk);
    write(0, 8'h30);
    push(0, 8'h30);
    wait_not_busy(0, 10);
    write(0, 8'h31);
    push(0, 8'h31);
    k = 0; nd = 0; d0 = 0; d1 = 0; prev = 1'b0;
    while (nd < 2 && k < 3 * 4340) begin
      @(negedge clk);
      k++;
      if (prev && nd == 1) begin
        chk("b2b_gap_tx", tx_a, 0);
        chk("b2b_gap_active", if_a.line_active, 1);
      end
      prev = if_a.tx_done;
      if (if_a.tx_done === 1'b1) begin
        if (nd == 0) d0 = k;
        else d1 = k;
        nd++;
      end
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_spacing", d1 - d0, 4340);
    wait_idle(0, 5000);

    // Overrun while holding register is full.
    write(0, 8'h30);
    push(0, 8'h30);
    repeat (3) @(negedge clk);
    write(0, 8'h31);
    push(0, 8'h31);
    write(0, 8'h55);
    chk("ovr_pulse", if_a.overrun, 1);
    chk("ovr_busy", if_a.tx_busy, 1);
    @(negedge clk);
    chk("ovr_pulse_end", if_a.overrun, 0);
    wait_idle(0, 9000);
    chk("ovr_count", ovr_a, 1);

    // Reset during data bit 4, with a byte queued behind it.
    repeat (3) @(negedge clk);
    write(0, 8'h41);
    repeat (2) @(negedge clk);
    write(0, 8'h42);
    repeat (5 * 434 + 100) @(negedge clk);
    chk("pre_reset_tx", tx_a, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", if_a.tx_busy, 0);
    chk("mid_rst_active", if_a.line_active, 0);
    chk("mid_rst_done", if_a.tx_done, 0);
    chk("mid_rst_overrun", if_a.overrun, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rel_active", if_a.line_active, 0);
    chk("rel_busy", if_a.tx_busy, 0);
    chk("rel_tx", tx_a, 1);
    write(0, 8'h31);
    push(0, 8'h31);
    @(negedge clk);
    wait_idle(0, 5000);

    // 8E2 frame on the fast instance.
    write(1, 8'h07);
    push(1, 8'h07);
    chk("par_busy", if_b.tx_busy, 1);
    @(negedge clk);
    chk("par_start", tx_b, 0);
    check_frame(1, 8'h07, 10, 12, 1'b1, 1'b0, 2);
    @(negedge clk);
    chk("par_post_active", if_b.line_active, 0);

    // Controller loop: 16 alternating characters.
    for (int i = 0; i < 16; i++) begin
      ch = (i % 2 == 1) ? ASCII_ONE : ASCII_ZERO;
      wait_not_busy(2, 200);
      write(2, ch);
      push(2, ch);
      chk("ctl_busy_after_strobe", if_c.tx_busy, 1);
    end
    @(negedge clk);
    wait_idle(2, 400);
    repeat (5) @(negedge clk);

    chk("ctl_overruns", ovr_c, 0);
    chk("ctl_frames", rx_frames[2], 16);
    chk("ctl_queue_empty", q2.size(), 0);
    chk("a_frames", rx_frames[0], 6);
    chk("a_queue_empty", q0.size(), 0);
    chk("b_frames", rx_frames[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
